// File: rtl/sitcp_axis_stream_bridge.sv
// sitcp_axis_stream_bridge
//   Bridges wide AXI-Stream user logic to the 8-bit SiTCP TCP FIFO interface.
//   Everything runs in the SiTCP_CLK domain. rst is synchronous, active-high.
//   TX: accepts TX_BYTES-wide beats and sends the enabled bytes, lowest byte first,
//       as registered TCP_TX_WR/TCP_TX_DATA pulses. TCP_TX_FULL holds the byte back.
//   RX: TCP_RX bytes go into an RX_FIFO_DEPTH byte FIFO. TCP_RX_WC reports the free
//       space. Bytes are packed into RX_BYTES-wide beats. A partial word is flushed
//       after RX_TIMEOUT idle cycles.
// Ports:
//   SiTCP_CLK, rst                      clock, synchronous active-high reset
//   tcp_open                            TCP_OPEN_ACK
//   s_axis_t{valid,data,keep,ready}     TX AXIS slave
//   tcp_tx_{full,wr,data}               SiTCP TX FIFO
//   tcp_rx_{wr,data,wc}                 SiTCP RX FIFO
//   m_axis_t{valid,data,keep,ready}     RX AXIS master
//   rx_overflow                         sticky, an RX byte was dropped
// Optional macro SITCP_BRIDGE_TLAST_EN adds m_axis_tlast. It is set only on beats
//   produced by the timeout flush.
module sitcp_axis_stream_bridge #(
    parameter int TX_BYTES      = 4,
    parameter int RX_BYTES      = 4,
    parameter int RX_FIFO_DEPTH = 2048,
    parameter int RX_TIMEOUT    = 255
) (
    input  logic                  SiTCP_CLK,
    input  logic                  rst,
    input  logic                  tcp_open,
    input  logic                  s_axis_tvalid,
    input  logic [8*TX_BYTES-1:0] s_axis_tdata,
    input  logic [TX_BYTES-1:0]   s_axis_tkeep,
    output logic                  s_axis_tready,
    input  logic                  tcp_tx_full,
    output logic                  tcp_tx_wr,
    output logic [7:0]            tcp_tx_data,
    input  logic                  tcp_rx_wr,
    input  logic [7:0]            tcp_rx_data,
    output logic [15:0]           tcp_rx_wc,
    output logic                  m_axis_tvalid,
    output logic [8*RX_BYTES-1:0] m_axis_tdata,
    output logic [RX_BYTES-1:0]   m_axis_tkeep,
    input  logic                  m_axis_tready,
`ifdef SITCP_BRIDGE_TLAST_EN
    output logic                  m_axis_tlast,
`endif
    output logic                  rx_overflow
);

    localparam int          AW      = $clog2(RX_FIFO_DEPTH);
    localparam int          FW      = (RX_BYTES > 1) ? $clog2(RX_BYTES) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(RX_FIFO_DEPTH);
    localparam logic [15:0] WC_RST  = (RX_FIFO_DEPTH > 65535) ? 16'hFFFF : 16'(RX_FIFO_DEPTH);

    // ---------------------------------------------------------------- TX path
    typedef enum logic {TX_EMPTY, TX_SEND} tx_state_e;

    tx_state_e             tx_state_q, tx_state_d;
    logic [8*TX_BYTES-1:0] tx_data_q, tx_data_d;
    logic [TX_BYTES-1:0]   tx_keep_q, tx_keep_d, tx_keep_clr;
    logic [7:0]            tx_byte;
    logic                  tx_last, tx_issue, tx_accept;
    logic                  tx_wr_q;
    logic [7:0]            tx_wdata_q;

    always_comb begin
        tx_byte     = '0;
        tx_keep_clr = tx_keep_q;
        // Scan downward so that the lowest enabled byte wins.
        for (int i = TX_BYTES-1; i >= 0; i--) begin
            if (tx_keep_q[i]) begin
                tx_byte        = tx_data_q[8*i +: 8];
                tx_keep_clr    = tx_keep_q;
                tx_keep_clr[i] = 1'b0;
            end
        end
        tx_last  = (tx_keep_clr == '0);
        tx_issue = (tx_state_q == TX_SEND) & tcp_open & ~tcp_tx_full;
        // Accepting during the final issue gives back-to-back beats with no bubble.
        s_axis_tready = ~rst & tcp_open & ((tx_state_q == TX_EMPTY) | (tx_issue & tx_last));
        tx_accept     = s_axis_tvalid & s_axis_tready;

        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_keep_d  = tx_keep_q;
        if (tx_accept) begin
            tx_data_d  = s_axis_tdata;
            tx_keep_d  = s_axis_tkeep;
            tx_state_d = (|s_axis_tkeep) ? TX_SEND : TX_EMPTY;
        end else if (tx_issue) begin
            tx_keep_d = tx_keep_clr;
            if (tx_last) tx_state_d = TX_EMPTY;
        end else if ((tx_state_q == TX_SEND) && !tcp_open) begin
            // The connection dropped: discard whatever is left of the beat.
            tx_keep_d  = '0;
            tx_state_d = TX_EMPTY;
        end
    end

    always_ff @(posedge SiTCP_CLK) begin
        if (rst) begin
            tx_state_q <= TX_EMPTY;
            tx_data_q  <= '0;
            tx_keep_q  <= '0;
            tx_wr_q    <= 1'b0;
            tx_wdata_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            tx_keep_q  <= tx_keep_d;
            tx_wr_q    <= tx_issue;
            if (tx_issue) tx_wdata_q <= tx_byte;
        end
    end

    assign tcp_tx_wr   = tx_wr_q;
    assign tcp_tx_data = tx_wdata_q;

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0]            mem_q [RX_FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [AW:0]           cnt_q, cnt_d, free_d;
    logic [15:0]           wc_q, wc_d;
    logic                  ovf_q;
    logic                  fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic [7:0]            rd_byte;

    assign fifo_full  = (cnt_q == DEPTH_C);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_wr    = tcp_rx_wr & ~fifo_full;
    assign rd_byte    = mem_q[rptr_q];

    always_comb begin
        cnt_d  = cnt_q + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, fifo_rd};
        free_d = DEPTH_C - cnt_d;
        wc_d   = (32'(free_d) >= 32'd65535) ? 16'hFFFF : 16'(free_d);
    end

    // Storage has no reset; the pointers and count define its contents.
    always_ff @(posedge SiTCP_CLK) begin
        if (fifo_wr) mem_q[wptr_q] <= tcp_rx_data;
    end

    // ---------------------------------------------------------------- RX packer
    logic [FW-1:0]         fill_q, fill_d;
    logic [8*RX_BYTES-1:0] word_q, word_d;
    logic [RX_BYTES-1:0]   okeep_q, okeep_d, part_mask;
    logic                  ovld_q, ovld_d;
    logic [15:0]           tmr_q, tmr_d;
    logic                  handshake, idle;
`ifdef SITCP_BRIDGE_TLAST_EN
    logic                  last_q, last_d;
`endif

    always_comb begin
        fill_d  = fill_q;
        word_d  = word_q;
        okeep_d = okeep_q;
        ovld_d  = ovld_q;
        tmr_d   = '0;
`ifdef SITCP_BRIDGE_TLAST_EN
        last_d  = last_q;
`endif
        for (int i = 0; i < RX_BYTES; i++) part_mask[i] = (i < int'(fill_q));

        handshake = ovld_q & m_axis_tready;
        // The output register counts as free in the cycle its beat is consumed.
        fifo_rd   = ~fifo_empty & (~ovld_q | m_axis_tready);
        // fill_q is always 0 while a beat is held, so "partial" implies ~ovld_q.
        idle      = ~ovld_q & (fill_q != '0) & fifo_empty & ~tcp_rx_wr;

        if (handshake) begin
            ovld_d  = 1'b0;
            word_d  = '0;
            okeep_d = '0;
`ifdef SITCP_BRIDGE_TLAST_EN
            last_d  = 1'b0;
`endif
        end
        if (fifo_rd) begin
            for (int i = 0; i < RX_BYTES; i++)
                if (i == int'(fill_q)) word_d[8*i +: 8] = rd_byte;
            if (int'(fill_q) == RX_BYTES-1) begin
                ovld_d  = 1'b1;
                okeep_d = '1;
                fill_d  = '0;
`ifdef SITCP_BRIDGE_TLAST_EN
                last_d  = 1'b0;
`endif
            end else begin
                fill_d = fill_q + FW'(1);
            end
        end
        if (idle) begin
            if (tmr_q == 16'(RX_TIMEOUT-1)) begin
                // Unfilled lanes are already zero: the word is cleared on handshake/reset.
                ovld_d  = 1'b1;
                okeep_d = part_mask;
                fill_d  = '0;
`ifdef SITCP_BRIDGE_TLAST_EN
                last_d  = 1'b1;
`endif
            end else begin
                tmr_d = tmr_q + 16'd1;
            end
        end
    end

    always_ff @(posedge SiTCP_CLK) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            wc_q    <= WC_RST;
            ovf_q   <= 1'b0;
            fill_q  <= '0;
            word_q  <= '0;
            okeep_q <= '0;
            ovld_q  <= 1'b0;
            tmr_q   <= '0;
`ifdef SITCP_BRIDGE_TLAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            if (fifo_wr) wptr_q <= wptr_q + AW'(1);
            if (fifo_rd) rptr_q <= rptr_q + AW'(1);
            if (tcp_rx_wr && fifo_full) ovf_q <= 1'b1;
            cnt_q   <= cnt_d;
            wc_q    <= wc_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            okeep_q <= okeep_d;
            ovld_q  <= ovld_d;
            tmr_q   <= tmr_d;
`ifdef SITCP_BRIDGE_TLAST_EN
            last_q  <= last_d;
`endif
        end
    end

    assign tcp_rx_wc     = wc_q;
    assign rx_overflow   = ovf_q;
    assign m_axis_tvalid = ovld_q;
    assign m_axis_tdata  = word_q;
    assign m_axis_tkeep  = okeep_q;
`ifdef SITCP_BRIDGE_TLAST_EN
    assign m_axis_tlast  = last_q;
`endif

endmodule
